// File: rtl/cluster_cfg_pkg.sv
// Shared types and size derivations for the configurable logic cluster.
// Every block that needs the chain geometry computes it from these functions.
package cluster_cfg_pkg;

   typedef enum logic [1:0] {
      UNCONFIG = 2'd0,
      LOADING  = 2'd1,
      ACTIVE   = 2'd2
   } cfg_state_t;

   // Smallest width that can encode 'value' distinct codes.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < value) result = b + 1;
      end
      return result;
   endfunction

   function automatic int le_width(input int k, input int i, input int n);
      return (2 ** k) + 1 + k * clog2(i + n);
   endfunction

   function automatic int cfg_total(input int k, input int n, input int i);
      return n * le_width(k, i, n);
   endfunction

endpackage

// File: rtl/logic_cluster_cfg_if.sv
// Configuration and logic I/O bundle of the cluster.
// The slave side is the cluster; the master side is whoever loads and drives it.
interface logic_cluster_cfg_if #(
   parameter int N = 4,
   parameter int I = 8
);
   logic         cfg_start;
   logic         cfg_valid;
   logic         cfg_bit;
   logic         cfg_out;
   logic         cfg_done;
   logic         active;
   logic [I-1:0] in;
   logic [N-1:0] out;

   modport master (
      output cfg_start, cfg_valid, cfg_bit, in,
      input  cfg_out, cfg_done, active, out
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_bit, in,
      output cfg_out, cfg_done, active, out
   );
endinterface

// File: rtl/logic_element.sv
// One K-input LUT with an output flip-flop and a registered/combinational output mux.
module logic_element #(
   parameter int K = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            active,
   input  logic [2**K-1:0] truth,
   input  logic            reg_sel,
   input  logic [K-1:0]    sel_in,
   output logic            q,
   output logic            out
);

   logic lut;

   assign lut = truth[sel_in];

   // The flop only runs while the cluster is active, so a fresh load always starts from 0.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         q <= 1'b0;
      end else if (active) begin
         q <= lut;
      end else begin
         q <= 1'b0;
      end
   end

   assign out = reg_sel ? q : lut;

endmodule

// File: rtl/logic_cluster_cfg.sv
// Serially configured cluster of N logic elements with input select muxes.
// The configuration chain also acts as a shift register for daisy-chained readback.
module logic_cluster_cfg
   import cluster_cfg_pkg::*;
#(
   parameter int K = 4,
   parameter int N = 4,
   parameter int I = 8
) (
   input logic                 clock,
   input logic                 reset,
   logic_cluster_cfg_if.slave  bus
);

   localparam int SEL_W     = clog2(I + N);
   localparam int LE_W      = le_width(K, I, N);
   localparam int CFG_TOTAL = cfg_total(K, N, I);
   localparam int TT_W      = 2 ** K;
   localparam int CNT_W     = clog2(CFG_TOTAL + 1);

   cfg_state_t             state;
   logic [CNT_W-1:0]       count;
   logic [CFG_TOTAL-1:0]   chain;
   logic                   done_r;
   logic                   active_r;
   logic [N-1:0]           le_q;
   logic [N-1:0]           le_out;
   logic [2**SEL_W-1:0]    src;

   // Configuration FSM: a start pulse always wins over data, and the last accepted
   // bit flips straight to ACTIVE with a one-cycle done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= UNCONFIG;
         count    <= '0;
         chain    <= '0;
         done_r   <= 1'b0;
         active_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (bus.cfg_start) begin
            state    <= LOADING;
            count    <= '0;
            active_r <= 1'b0;
         end else begin
            case (state)
               LOADING: begin
                  if (bus.cfg_valid) begin
                     chain <= {chain[CFG_TOTAL-2:0], bus.cfg_bit};
                     if (count == CNT_W'(CFG_TOTAL - 1)) begin
                        state    <= ACTIVE;
                        count    <= '0;
                        done_r   <= 1'b1;
                        active_r <= 1'b1;
                     end else begin
                        count <= count + CNT_W'(1);
                     end
                  end
               end
               UNCONFIG, ACTIVE: begin
                  state <= state;
               end
               default: begin
                  state    <= UNCONFIG;
                  active_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Select sources: external inputs, then LE flop outputs, then constant zeros.
   // Only registered LE outputs are offered, which rules out combinational loops.
   always_comb begin
      src            = '0;
      src[I+N-1:0]   = {le_q, bus.in};
   end

   for (genvar j = 0; j < N; j++) begin : g_le
      logic [K-1:0] sel_in;

      always_comb begin
         sel_in = '0;
         for (int i = 0; i < K; i++) begin
            sel_in[i] = src[chain[j*LE_W + TT_W + 1 + i*SEL_W +: SEL_W]];
         end
      end

      logic_element #(.K(K)) u_le (
         .clock   (clock),
         .reset   (reset),
         .clear   (bus.cfg_start),
         .active  (active_r),
         .truth   (chain[j*LE_W +: TT_W]),
         .reg_sel (chain[j*LE_W + TT_W]),
         .sel_in  (sel_in),
         .q       (le_q[j]),
         .out     (le_out[j])
      );
   end

   assign bus.cfg_out  = chain[CFG_TOTAL-1];
   assign bus.cfg_done = done_r;
   assign bus.active   = active_r;
   assign bus.out      = active_r ? le_out : '0;

endmodule

// File: doc/logic_cluster_cfg.md
LOGIC_CLUSTER_CFG -- requirements
Module: logic_cluster_cfg

Interface
REQ-001 SHALL have parameter K, default 4, giving the number of inputs per logic-element LUT.
REQ-002 SHALL have parameter N, default 4, giving the number of logic elements (LEs) in the cluster.
REQ-003 SHALL have parameter I, default 8, giving the number of external cluster inputs.
REQ-004 SHALL derive SEL_W = clog2(I+N), LE_W = 2^K + 1 + K*SEL_W and CFG_TOTAL = N*LE_W; at defaults these are 4, 33 and 132.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clock  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 cfg_start  input  1  pulse that begins a configuration load.
REQ-009 cfg_valid  input  1  qualifies cfg_bit during a load.
REQ-010 cfg_bit  input  1  serial configuration data, sent MSB (index CFG_TOTAL-1) first.
REQ-011 cfg_out  output  1  daisy-chain output, equal to chain bit CFG_TOTAL-1.
REQ-012 cfg_done  output  1  one-cycle pulse when the load completes.
REQ-013 active  output  1  high while the cluster is configured and operating.
REQ-014 in  input  I  external logic inputs.
REQ-015 out  output  N  LE outputs.

Function
REQ-016 SHALL implement FSM states UNCONFIG, LOADING and ACTIVE.
REQ-017 In any state, cfg_start SHALL clear the bit counter and LE flip-flops and enter LOADING; a cfg_valid in the same cycle SHALL be ignored.
REQ-018 In LOADING, each cycle with cfg_valid=1 SHALL shift cfg_bit into chain bit 0, move every bit up one position and increment the counter.
REQ-019 In LOADING, cfg_valid=0 SHALL hold the chain and the counter.
REQ-020 On the accepted bit that brings the count to CFG_TOTAL, the next cycle SHALL have state=ACTIVE, active=1 and cfg_done=1 for exactly one cycle.
REQ-021 In UNCONFIG and ACTIVE, cfg_valid SHALL be ignored and the chain held.
REQ-022 cfg_out SHALL be the registered chain bit CFG_TOTAL-1, so the bit sent CFG_TOTAL accepted shifts earlier reappears.
REQ-023 LE j configuration SHALL occupy chain[j*LE_W +: LE_W] as follows:
- [0 +: 2^K]: truth table.
- bit 2^K: reg_sel.
- then K fields of SEL_W bits: input selects, with input 0 lowest.
REQ-024 Select code s<I SHALL choose in[s]; code I+m (m<N) SHALL choose LE m's flip-flop Q; any code >= I+N SHALL choose constant 0.
REQ-025 No select path SHALL route combinational LE outputs, so no combinational loop can form.
REQ-026 The LUT output SHALL be truth[addr], where addr bit i is selected input i.
REQ-027 The LE flip-flop SHALL load the LUT output every cycle while active=1 and hold 0 otherwise.
REQ-028 out[j] SHALL be flip-flop Q when reg_sel=1, or the combinational LUT output when reg_sel=0.
REQ-029 out SHALL be forced to 0 whenever active=0.
REQ-030 LUT and select decode SHALL be purely combinational: a change on in reaches an unregistered out in the same cycle, and a registered out one cycle later.

Reset
REQ-031 reset SHALL clear the state to UNCONFIG, the counter to 0, all chain bits to 0 and all LE flip-flops to 0.
REQ-032 After reset, cfg_out, cfg_done, active and out SHALL all be 0.
REQ-033 reset SHALL take priority over cfg_start and cfg_valid.
REQ-034 reset mid-load SHALL abandon the load; a fresh cfg_start plus CFG_TOTAL bits SHALL then be required.

Structure
REQ-035 A shared package cluster_cfg_pkg SHALL hold the state enum, the clog2 function and the LE_W/CFG_TOTAL derivation functions.
REQ-036 One sub-module, logic_element, SHALL hold one K-input LUT, the flip-flop and the reg_sel output mux, instantiated N times through generate.
REQ-037 The input select muxes and the configuration FSM SHALL reside in logic_cluster_cfg.

Verification (defaults K=4, N=4, I=8)
REQ-038 Reset: assert reset 2 cycles -> active=0, cfg_done=0, out=4'h0, cfg_out=0.
REQ-039 AND gate, combinational:
- Stimulus: LE0 truth=16'h0008, reg_sel=0, sels={15,15,1,0}; all other LEs zero; send 132 bits.
- Response: cfg_done pulses once, active=1; in=8'h03 -> out[0]=1; in=8'h01 -> out[0]=0.
REQ-040 Registered toggle: LE1 truth=16'h5555, reg_sel=1, sel0=9, other sels=15 -> out[1] alternates 0,1,0,... starting the first active cycle.
REQ-041 Gapped load: drop cfg_valid for 10 cycles at bit 60 -> cfg_done arrives 10 cycles late and the configuration is identical.
REQ-042 Restart and readback:
- Restart: cfg_start at bit 50 -> counter restarts, active stays 0, and 132 further bits are required.
- Readback: cfg_out reproduces the sent stream delayed by 132 accepted bits.
REQ-043 Reset mid-load at bit 100 -> UNCONFIG, and cfg_valid is ignored until cfg_start.
